// File: rtl/fp_add_pkg.sv
// Shared constants and state encoding for the single-precision adder pipeline.
package fp_add_pkg;
  localparam int SIG_W     = 24;
  localparam int GRS_W     = 3;
  localparam int SAT_SHIFT = SIG_W + GRS_W;
  localparam int SMALL_W   = SIG_W + GRS_W;
  localparam int SWAP_BIT  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } align_state_e;
endpackage

// File: rtl/fp_align_shift.sv
// Significand alignment stage: picks big/small operands and right-shifts the small one
// a bit per cycle. Define FP_ALIGN_STICKY_EN to fold shifted-out bits into a sticky bit.
module fp_align_shift
  import fp_add_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [8:0]         exp_diff,
  input  logic [7:0]         larger,
  input  logic [SIG_W-1:0]   sig_A,
  input  logic [SIG_W-1:0]   sig_B,
  output logic [SIG_W-1:0]   big_sig,
  output logic [SMALL_W-1:0] small_sig,
  output logic [7:0]         exp_out,
  output logic               swap,
  output logic               busy,
  output logic               done
);
  localparam logic [7:0] SAT_N = 8'(SAT_SHIFT);

  align_state_e       state_q, state_d;
  logic [7:0]         count_q, count_d;
  logic [SIG_W-1:0]   big_q, big_d;
  logic [SMALL_W-1:0] small_q, small_d;
  logic [7:0]         exp_q, exp_d;
  logic               swap_q, swap_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [SIG_W-1:0]   other_sig;
  logic [7:0]         shift_n;
  logic [SMALL_W-1:0] load_val;
  logic [SMALL_W-1:0] step_val;
  logic [SMALL_W-1:0] sat_val;

  assign other_sig = exp_diff[SWAP_BIT] ? sig_A : sig_B;
  assign shift_n   = exp_diff[SWAP_BIT-1:0];
  assign load_val  = {other_sig, {GRS_W{1'b0}}};

`ifdef FP_ALIGN_STICKY_EN
  // Bit 0 acts as sticky: it absorbs everything that falls past the round position.
  assign step_val = {1'b0, small_q[SMALL_W-1:2], small_q[1] | small_q[0]};
  assign sat_val  = {{(SMALL_W-1){1'b0}}, |other_sig};
`else
  assign step_val = {1'b0, small_q[SMALL_W-1:1]};
  assign sat_val  = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      big_q   <= '0;
      small_q <= '0;
      exp_q   <= '0;
      swap_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      big_q   <= big_d;
      small_q <= small_d;
      exp_q   <= exp_d;
      swap_q  <= swap_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    big_d   = big_q;
    small_d = small_q;
    exp_d   = exp_q;
    swap_d  = swap_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          exp_d  = larger;
          swap_d = exp_diff[SWAP_BIT];
          big_d  = exp_diff[SWAP_BIT] ? sig_B : sig_A;
          busy_d = 1'b1;
          if (shift_n == 8'd0) begin
            small_d = load_val;
            state_d = DONE;
            done_d  = 1'b1;
          end else if (shift_n >= SAT_N) begin
            small_d = sat_val;
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            small_d = load_val;
            count_d = shift_n;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        small_d = step_val;
        count_d = count_q - 8'd1;
        if (count_q == 8'd1) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign big_sig   = big_q;
  assign small_sig = small_q;
  assign exp_out   = exp_q;
  assign swap      = swap_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule

// File: tb/tb_fp_align_shift.sv
// Randomised bench for fp_align_shift against an arithmetic model of the alignment rules.
module tb_fp_align_shift;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [8:0]  exp_diff;
  logic [7:0]  larger;
  logic [23:0] sig_A, sig_B;
  logic [23:0] big_sig;
  logic [26:0] small_sig;
  logic [7:0]  exp_out;
  logic        swap, busy, done;

`ifdef FP_ALIGN_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned cyc = 0;

  fp_align_shift dut (
    .clk(clk), .rst_n(rst_n), .start(start), .exp_diff(exp_diff), .larger(larger),
    .sig_A(sig_A), .sig_B(sig_B), .big_sig(big_sig), .small_sig(small_sig),
    .exp_out(exp_out), .swap(swap), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Aligned small operand computed directly from the shift amount.
  function automatic logic [26:0] model_small(input logic [23:0] o, input int n);
    longint full;
    longint res;
    full = longint'(o) * 8;
    if (n == 0) return 27'(full);
    if (n >= 27) return (STICKY && o != 0) ? 27'd1 : 27'd0;
    res = full >> n;
    if (STICKY && (full % (64'd1 << n)) != 0) res = res | 1;
    return 27'(res);
  endfunction

  // Reference: edge-indexed transaction model.
  int unsigned mk;
  bit          m_busy;
  int unsigned m_end;
  logic        e_busy, e_done, e_swap;
  logic [23:0] e_big;
  logic [26:0] e_small;
  logic [7:0]  e_exp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mk = 0; m_busy = 0; m_end = 0;
      e_busy = 0; e_done = 0; e_swap = 0;
      e_big = '0; e_small = '0; e_exp = '0;
    end else begin
      int n;
      mk++;
      if (m_busy && mk == m_end + 1) begin
        m_busy = 0;
      end else if (!m_busy && start) begin
        n       = int'(exp_diff[7:0]);
        e_swap  = exp_diff[8];
        e_exp   = larger;
        e_big   = e_swap ? sig_B : sig_A;
        e_small = model_small(e_swap ? sig_A : sig_B, n);
        m_end   = mk + ((n >= 1 && n <= 26) ? n : 0);
        m_busy  = 1;
      end
      e_busy = m_busy;
      e_done = m_busy && (mk == m_end);
    end
  end

  always @(negedge clk) begin
    check("busy", {31'd0, busy}, {31'd0, e_busy});
    check("done", {31'd0, done}, {31'd0, e_done});
    if (!e_busy || e_done) begin
      check("big_sig", {8'd0, big_sig}, {8'd0, e_big});
      check("small_sig", {5'd0, small_sig}, {5'd0, e_small});
      check("exp_out", {24'd0, exp_out}, {24'd0, e_exp});
      check("swap", {31'd0, swap}, {31'd0, e_swap});
    end
  end

  task automatic run_op(input logic [8:0] d, input logic [7:0] l, input logic [23:0] a,
                        input logic [23:0] b, input logic [23:0] x_big, input logic [26:0] x_small,
                        input logic x_swap, input int x_m, input string tag);
    int unsigned c0;
    int k;
    @(negedge clk);
    exp_diff = d; larger = l; sig_A = a; sig_B = b; start = 1'b1;
    c0 = cyc;
    @(posedge clk);
    #1 start = 1'b0;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (k == 100) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_lat"}, cyc - c0 - 1, 32'(x_m));
      check({tag, "_big"}, {8'd0, big_sig}, {8'd0, x_big});
      check({tag, "_small"}, {5'd0, small_sig}, {5'd0, x_small});
      check({tag, "_swap"}, {31'd0, swap}, {31'd0, x_swap});
      check({tag, "_exp"}, {24'd0, exp_out}, {24'd0, l});
    end
    $display("[TB] op %s diff=%h A=%h B=%h -> big=%h small=%h swap=%b exp=%h",
             tag, d, a, b, big_sig, small_sig, swap, exp_out);
  endtask

  initial begin
    int k;
    int ndone;
    int unsigned c0;
    rst_n = 1'b0; start = 1'b0; exp_diff = '0; larger = '0; sig_A = '0; sig_B = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_small", {5'd0, small_sig}, 32'd0);
    rst_n = 1'b1;

    run_op(9'h000, 8'h7F, 24'hC00000, 24'h800001, 24'hC00000, 27'h4000008, 1'b0, 0, "n0");
    run_op(9'h005, 8'h85, 24'hA00000, 24'h800001, 24'hA00000,
           STICKY ? 27'h0200001 : 27'h0200000, 1'b0, 5, "n5");
    run_op(9'h100, 8'h81, 24'h900003, 24'hF00000, 24'hF00000, 27'h4800018, 1'b1, 0, "swap");
    run_op(9'h01E, 8'h90, 24'h800000, 24'h800000, 24'h800000,
           STICKY ? 27'h0000001 : 27'h0000000, 1'b0, 0, "sat30");
    run_op(9'h01B, 8'h90, 24'h800000, 24'h800001, 24'h800000,
           STICKY ? 27'h0000001 : 27'h0000000, 1'b0, 0, "sat27");
    run_op(9'h019, 8'h91, 24'h800000, 24'h800001, 24'h800000,
           STICKY ? 27'h0000003 : 27'h0000002, 1'b0, 25, "n25");
    run_op(9'h001, 8'h92, 24'hFFFFFF, 24'h800001, 24'hFFFFFF, 27'h2000004, 1'b0, 1, "n1");

    // Second start two cycles into a 10-step shift must be dropped.
    @(negedge clk);
    exp_diff = 9'h00A; larger = 8'h10; sig_A = 24'hC00000; sig_B = 24'hFFFFFF; start = 1'b1;
    c0 = cyc;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); @(posedge clk);
    #1 exp_diff = 9'h000; larger = 8'h22; sig_A = 24'h123456; sig_B = 24'h654321; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    ndone = 0;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        check("ign_lat", cyc - c0 - 1, 32'd10);
        check("ign_small", {5'd0, small_sig}, 32'h001FFFF);
        check("ign_exp", {24'd0, exp_out}, 32'h10);
      end
    end
    check("ign_ndone", 32'(ndone), 32'd1);
    $display("[TB] op busy_ignore dones=%0d small=%h", ndone, small_sig);

    // Asynchronous reset in the middle of a shift.
    @(negedge clk);
    exp_diff = 9'h014; larger = 8'h33; sig_A = 24'hFFFFFF; sig_B = 24'hABCDEF; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_big", {8'd0, big_sig}, 32'd0);
    check("mid_rst_small", {5'd0, small_sig}, 32'd0);
    check("mid_rst_exp", {24'd0, exp_out}, 32'd0);
    ndone = 0;
    for (k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    rst_n = 1'b1;
    for (k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("mid_rst_nodone", 32'(ndone), 32'd0);
    $display("[TB] op reset_mid_shift dones=%0d", ndone);
    run_op(9'h003, 8'h44, 24'hFFFFFF, 24'h800001, 24'hFFFFFF, 27'h0800001, 1'b0, 3, "post_rst");

    // Random traffic, including starts while busy.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] n;
      @(negedge clk);
      case ($urandom % 4)
        0: n = 8'd0;
        1: n = 8'($urandom_range(1, 26));
        2: n = 8'($urandom_range(27, 255));
        default: n = 8'($urandom);
      endcase
      exp_diff = {1'($urandom), n};
      larger   = 8'($urandom);
      sig_A    = 24'($urandom) | 24'h800000;
      sig_B    = (($urandom % 8) == 0) ? 24'($urandom % 4) : (24'($urandom) | 24'h800000);
      start    = (($urandom % 3) == 0);
      if (start && !busy)
        $display("[TB] rand issue diff=%h A=%h B=%h", exp_diff, sig_A, sig_B);
    end
    @(negedge clk) start = 1'b0;
    repeat (40) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
